fft32_stage_scheduler: RTL



---
 rtl/fft32_stage_scheduler_if.sv | 46 ++++
 rtl/fft32_stage_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fft32_stage_scheduler_if.sv
// Handshake/bus bundle between the FFT scheduler and the
// butterfly datapath / sample memory.
interface fft32_stage_scheduler_if;
  logic       start;
  logic       busy;
  logic       bf_valid;
  logic [4:0] addr_a;
  logic [4:0] addr_b;
  logic [3:0] tw_idx;
  logic [2:0] stage;
  logic       wr_en;
  logic [4:0] wr_addr_a;
  logic [4:0] wr_addr_b;
  logic       done;
  logic       flag;

  modport master (
    input  start,
    output busy,
    output bf_valid,
    output addr_a,
    output addr_b,
    output tw_idx,
    output stage,
    output wr_en,
    output wr_addr_a,
    output wr_addr_b,
    output done,
    output flag
  );

  modport slave (
    output start,
    input  busy,
    input  bf_valid,
    input  addr_a,
    input  addr_b,
    input  tw_idx,
    input  stage,
    input  wr_en,
    input  wr_addr_a,
    input  wr_addr_b,
    input  done,
    input  flag
  );
endinterface

// File: rtl/fft32_stage_scheduler.sv
// 32-point radix-2 DIT FFT scheduler: drives one shared butterfly
// over 5 stages x 16 butterflies with delayed in-place write-back.
module fft32_stage_scheduler #(
  parameter int BF_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  fft32_stage_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] LAT = 4'(BF_LAT);

  state_t     r_state;
  state_t     w_state_nx;
  logic [2:0] r_s;
  logic [2:0] w_s_nx;
  logic [3:0] r_j;
  logic [3:0] w_j_nx;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nx;
  logic       w_issue;
  logic       w_done_nx;
  logic       w_flag_nx;
  logic       w_busy_nx;

  logic       r_busy;
  logic       r_bf_valid;
  logic [4:0] r_addr_a;
  logic [4:0] r_addr_b;
  logic [3:0] r_tw;
  logic [2:0] r_stage;
  logic       r_done;
  logic       r_flag;

  logic [4:0] w_j5;
  logic [4:0] w_half;
  logic [4:0] w_pos;
  logic [4:0] w_grp;
  logic [4:0] w_addr_a;
  logic [4:0] w_addr_b;
  logic [3:0] w_tw;

  logic       r_pv [BF_LAT];
  logic [4:0] r_pa [BF_LAT];
  logic [4:0] r_pb [BF_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_s        <= 3'd0;
      r_j        <= 4'd0;
      r_cnt      <= 4'd0;
      r_busy     <= 1'b0;
      r_bf_valid <= 1'b0;
      r_addr_a   <= 5'd0;
      r_addr_b   <= 5'd0;
      r_tw       <= 4'd0;
      r_stage    <= 3'd0;
      r_done     <= 1'b0;
      r_flag     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_s        <= w_s_nx;
      r_j        <= w_j_nx;
      r_cnt      <= w_cnt_nx;
      r_busy     <= w_busy_nx;
      r_bf_valid <= w_issue;
      r_done     <= w_done_nx;
      r_flag     <= w_flag_nx;
      if (w_issue) begin
        r_addr_a <= w_addr_a;
        r_addr_b <= w_addr_b;
        r_tw     <= w_tw;
        r_stage  <= w_s_nx;
      end
    end
  end

  // Outputs are registered from the next state, so the state and
  // the visible strobes always refer to the same cycle.
  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_j_nx     = r_j;
    w_cnt_nx   = r_cnt;
    w_issue    = 1'b0;
    w_done_nx  = 1'b0;
    w_flag_nx  = r_flag;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nx = S_RUN;
          w_s_nx     = 3'd0;
          w_j_nx     = 4'd0;
          w_issue    = 1'b1;
          w_flag_nx  = 1'b0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_j == 4'd15) begin
          w_state_nx = S_DRAIN;
          w_cnt_nx   = 4'd1;
        end else begin
          w_j_nx  = r_j + 4'd1;
          w_issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == LAT) begin
          if (r_s == 3'd4) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
            w_flag_nx  = 1'b1;
          end else begin
            w_state_nx = S_RUN;
            w_s_nx     = r_s + 3'd1;
            w_j_nx     = 4'd0;
            w_issue    = 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    w_busy_nx = (w_state_nx == S_RUN) ||
                (w_state_nx == S_DRAIN);
  end

  // Group/position split of j gives the in-place DIT leg pair.
  always_comb begin
    w_j5     = {1'b0, w_j_nx};
    w_half   = 5'd1 << w_s_nx;
    w_pos    = w_j5 & (w_half - 5'd1);
    w_grp    = w_j5 >> w_s_nx;
    w_addr_a = (w_grp << (w_s_nx + 3'd1)) | w_pos;
    w_addr_b = w_addr_a | w_half;
    w_tw     = 4'(w_pos << (3'd4 - w_s_nx));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BF_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= 5'd0;
        r_pb[i] <= 5'd0;
      end
    end else begin
      r_pv[0] <= r_bf_valid;
      r_pa[0] <= r_addr_a;
      r_pb[0] <= r_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.bf_valid  = r_bf_valid;
  assign bus.addr_a    = r_addr_a;
  assign bus.addr_b    = r_addr_b;
  assign bus.tw_idx    = r_tw;
  assign bus.stage     = r_stage;
  assign bus.wr_en     = r_pv[BF_LAT-1];
  assign bus.wr_addr_a = r_pa[BF_LAT-1];
  assign bus.wr_addr_b = r_pb[BF_LAT-1];
  assign bus.done      = r_done;
  assign bus.flag      = r_flag;

endmodule
